// File: rtl/uplink_frame_tx_if.sv
// Message handshake between the packet source and the uplink frame transmitter.
interface uplink_frame_tx_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  msg_valid;
  logic                  msg_ready;
  logic [ID_WIDTH-1:0]   msg_id;
  logic [DATA_WIDTH-1:0] msg_data;

  modport master (output msg_valid, msg_id, msg_data, input msg_ready);
  modport slave  (input msg_valid, msg_id, msg_data, output msg_ready);
endinterface

// File: rtl/uplink_frame_tx.sv
// Uplink transmitter: one frame per accepted message (alternating preamble,
// message ID MSB first, optionally LFSR-scrambled data MSB first, then a guard gap).
module uplink_frame_tx #(
  parameter int DIV_WIDTH      = 8,
  parameter int PREAMBLE_COUNT = 8,
  parameter int ID_WIDTH       = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int SCRAMBLE_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] clk_div,
  uplink_frame_tx_if.slave     msg,
  output logic                 ul_out,
  output logic                 ul_en,
  output logic                 busy
);

  localparam int MAX_PI    = (PREAMBLE_COUNT > ID_WIDTH) ? PREAMBLE_COUNT : ID_WIDTH;
  localparam int MAX_FIELD = (MAX_PI > DATA_WIDTH) ? MAX_PI : DATA_WIDTH;
  localparam int BIT_W     = (MAX_FIELD > 1) ? $clog2(MAX_FIELD) : 1;

  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_COUNT - 1);
  localparam logic [BIT_W-1:0] ID_LAST   = BIT_W'(ID_WIDTH - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [6:0]       LFSR_SEED = 7'h7F;
  localparam bit               SCR       = (SCRAMBLE_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ID, S_DATA, S_GAP
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  per_cnt;
  logic [DIV_WIDTH-1:0]  p_last;   // latched period minus one
  logic [BIT_W-1:0]      bit_cnt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [6:0]            lfsr;

  logic       accept;
  logic       wrap;
  logic       data_bit;
  logic [6:0] lfsr_next;

  // Ready drops combinationally with rst so nothing is accepted while reset is held.
  assign msg.msg_ready = (state == S_IDLE) && !rst;
  assign accept        = msg.msg_valid && msg.msg_ready;
  assign wrap          = (per_cnt == p_last);
  assign data_bit      = data_q[DATA_WIDTH-1] ^ (SCR & lfsr[6]);
  assign lfsr_next     = {lfsr[5:0], lfsr[6] ^ lfsr[5]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      per_cnt <= '0;
      p_last  <= '0;
      bit_cnt <= '0;
      id_q    <= '0;
      data_q  <= '0;
      lfsr    <= LFSR_SEED;
      ul_out  <= 1'b0;
      ul_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ul_out <= 1'b0;
          ul_en  <= 1'b0;
          busy   <= 1'b0;
          if (accept) begin
            state   <= S_PREAMBLE;
            id_q    <= msg.msg_id;
            data_q  <= msg.msg_data;
            p_last  <= (clk_div == '0) ? '0 : clk_div - DIV_WIDTH'(1);
            per_cnt <= '0;
            bit_cnt <= '0;
            lfsr    <= LFSR_SEED;
            ul_out  <= 1'b1;
            ul_en   <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          per_cnt <= wrap ? '0 : per_cnt + DIV_WIDTH'(1);
          if (wrap) begin
            if (bit_cnt == PRE_LAST) begin
              state   <= S_ID;
              bit_cnt <= '0;
              ul_out  <= id_q[ID_WIDTH-1];
              id_q    <= id_q << 1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              ul_out  <= ~ul_out;
            end
          end
        end

        S_ID: begin
          per_cnt <= wrap ? '0 : per_cnt + DIV_WIDTH'(1);
          if (wrap) begin
            if (bit_cnt == ID_LAST) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
            // The bit loaded here is either the next ID bit or the first data bit.
            if (bit_cnt == ID_LAST) begin
              ul_out <= data_bit;
              data_q <= data_q << 1;
              lfsr   <= lfsr_next;
            end else begin
              ul_out <= id_q[ID_WIDTH-1];
              id_q   <= id_q << 1;
            end
          end
        end

        S_DATA: begin
          per_cnt <= wrap ? '0 : per_cnt + DIV_WIDTH'(1);
          if (wrap) begin
            if (bit_cnt == DATA_LAST) begin
              state   <= S_GAP;
              bit_cnt <= '0;
              ul_out  <= 1'b0;
              ul_en   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              ul_out  <= data_bit;
              data_q  <= data_q << 1;
              lfsr    <= lfsr_next;
            end
          end
        end

        S_GAP: begin
          per_cnt <= wrap ? '0 : per_cnt + DIV_WIDTH'(1);
          ul_out  <= 1'b0;
          ul_en   <= 1'b0;
          if (wrap) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          per_cnt <= '0;
          bit_cnt <= '0;
          ul_out  <= 1'b0;
          ul_en   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uplink_frame_tx.sv
// Self-checking bench: raw and scrambled transmitters driven in lockstep and
// compared cycle by cycle against a frame-level reference model.
module tb_uplink_frame_tx;

  localparam int PRE = 8;
  localparam int IDW = 4;
  localparam int DW  = 16;
  localparam int FB  = PRE + IDW + DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] clk_div = 8'd1;
  logic       raw_out, raw_en, raw_busy;
  logic       scr_out, scr_en, scr_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [FB-1:0] obs_raw, obs_scr;

  always #5 clk = ~clk;

  uplink_frame_tx_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) raw_if ();
  uplink_frame_tx_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) scr_if ();

  uplink_frame_tx #(.DIV_WIDTH(8), .PREAMBLE_COUNT(PRE), .ID_WIDTH(IDW),
                    .DATA_WIDTH(DW), .SCRAMBLE_EN(0)) u_raw (
    .clk(clk), .rst(rst), .clk_div(clk_div), .msg(raw_if),
    .ul_out(raw_out), .ul_en(raw_en), .busy(raw_busy));

  uplink_frame_tx #(.DIV_WIDTH(8), .PREAMBLE_COUNT(PRE), .ID_WIDTH(IDW),
                    .DATA_WIDTH(DW), .SCRAMBLE_EN(1)) u_scr (
    .clk(clk), .rst(rst), .clk_div(clk_div), .msg(scr_if),
    .ul_out(scr_out), .ul_en(scr_en), .busy(scr_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: element FB-1 is the first bit on the wire.
  function automatic logic [FB-1:0] frame_bits(input int id, input int data, input bit scr);
    logic [FB-1:0] f;
    int pos;
    int ks;
    pos = FB - 1;
    for (int i = 0; i < PRE; i++) begin
      f[pos] = (i % 2 == 0);
      pos--;
    end
    for (int i = 0; i < IDW; i++) begin
      f[pos] = ((id >> (IDW - 1 - i)) & 1) != 0;
      pos--;
    end
    ks = 'h7F;
    for (int i = 0; i < DW; i++) begin
      f[pos] = ((((data >> (DW - 1 - i)) & 1) ^ (scr ? ((ks >> 6) & 1) : 0)) != 0);
      pos--;
      ks = ((ks * 2) % 128) + (((ks >> 6) ^ (ks >> 5)) & 1);
    end
    return f;
  endfunction

  task automatic drive(input logic v, input logic [IDW-1:0] id, input logic [DW-1:0] data);
    raw_if.msg_valid = v;  raw_if.msg_id = id;  raw_if.msg_data = data;
    scr_if.msg_valid = v;  scr_if.msg_id = id;  scr_if.msg_data = data;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(raw_if.msg_ready && scr_if.msg_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {raw_if.msg_ready, scr_if.msg_ready}, 2'b11);
  endtask

  task automatic run_frame(input logic [IDW-1:0] id, input logic [DW-1:0] data, input logic [7:0] div);
    int p;
    logic [FB-1:0] exp_raw, exp_scr;
    p = (div == 0) ? 1 : int'(div);
    exp_raw = frame_bits(int'(id), int'(data), 1'b0);
    exp_scr = frame_bits(int'(id), int'(data), 1'b1);
    wait_ready();
    drive(1'b1, id, data);
    clk_div = div;
    @(negedge clk);
    drive(1'b0, IDW'($urandom), DW'($urandom));
    for (int k = 0; k < FB * p; k++) begin
      int b;
      b = FB - 1 - k / p;
      check("raw_en", raw_en, 1'b1);
      check("scr_en", scr_en, 1'b1);
      check("raw_bit", raw_out, exp_raw[b]);
      check("scr_bit", scr_out, exp_scr[b]);
      check("busy_frame", {raw_busy, scr_busy}, 2'b11);
      check("ready_busy", {raw_if.msg_ready, scr_if.msg_ready}, 2'b00);
      if (k % p == 0) begin
        obs_raw[b] = raw_out;
        obs_scr[b] = scr_out;
      end
      if (k == 5) clk_div = 8'($urandom);
      @(negedge clk);
    end
    for (int k = 0; k < p; k++) begin
      check("gap_en_out", {raw_en, raw_out, scr_en, scr_out}, 4'b0000);
      check("gap_busy", {raw_busy, scr_busy}, 2'b11);
      check("gap_ready", {raw_if.msg_ready, scr_if.msg_ready}, 2'b00);
      @(negedge clk);
    end
    check("idle_ready", {raw_if.msg_ready, scr_if.msg_ready}, 2'b11);
    check("idle_busy", {raw_busy, scr_busy}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc[3];
    int n_acc;
    int cyc;

    drive(1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {raw_out, raw_en, raw_busy, scr_out, scr_en, scr_busy}, 6'b0);
    check("rst_ready", {raw_if.msg_ready, scr_if.msg_ready}, 2'b00);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {raw_if.msg_ready, scr_if.msg_ready}, 2'b11);
    @(negedge clk);

    // Directed: single-cycle bits, all-zero data exposes the scrambler keystream.
    run_frame(4'hA, 16'h0000, 8'd1);
    check("t1_frame", obs_raw, 28'hAAA_0000);
    check("t3_first8", obs_scr[15:8], 8'hFE);

    // Three-cycle bits and a zero divider (treated as one).
    run_frame(4'hA, 16'h0000, 8'd3);
    run_frame(4'h5, 16'hFFFF, 8'd0);

    // Randomized frames; clk_div is scrambled mid-frame inside run_frame.
    for (int i = 0; i < 6; i++)
      run_frame(IDW'($urandom), DW'($urandom), 8'($urandom_range(0, 4)));

    // Back-to-back with msg_valid held high.
    wait_ready();
    clk_div = 8'd2;
    drive(1'b1, 4'h3, 16'h1234);
    n_acc = 0;
    cyc = 0;
    while (n_acc < 3 && cyc < 400) begin
      if (raw_if.msg_ready) begin
        t_acc[n_acc] = cyc;
        n_acc++;
      end
      if (n_acc < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      check("b2b_space1", t_acc[1] - t_acc[0], 59);
      check("b2b_space2", t_acc[2] - t_acc[1], 59);
    end
    @(negedge clk);
    drive(1'b0, '0, '0);

    // Reset during the ID field aborts the frame immediately.
    wait_ready();
    drive(1'b1, 4'hC, 16'hBEEF);
    clk_div = 8'd2;
    @(negedge clk);
    drive(1'b0, '0, '0);
    repeat (PRE * 2 + 3) @(negedge clk);
    check("pre_abort_en", {raw_en, scr_en}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("abort_outputs", {raw_out, raw_en, raw_busy, scr_out, scr_en, scr_busy}, 6'b0);
    check("abort_ready", {raw_if.msg_ready, scr_if.msg_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_release_ready", {raw_if.msg_ready, scr_if.msg_ready}, 2'b11);
    @(negedge clk);
    run_frame(IDW'($urandom), DW'($urandom), 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
